// File: rtl/seqdet_param.sv
// Serial sequence detector with a runtime-loadable 1..MAX_LEN bit pattern.
// Overlap and Mealy/Moore output timing are selectable; matches are counted with saturation.
module seqdet_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cfg_moore,
    input  logic                         en,
    input  logic                         x,
    input  logic                         clr_cnt,
    output logic                         z,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cfg_err
);
    localparam int LW = $clog2(MAX_LEN+1);

    logic [MAX_LEN-1:0] pattern, hist, nh, mask;
    logic [LW-1:0]      len, fill, fill_inc;
    logic               overlap, moore, z_reg;
    logic               sample, match;

    always_comb begin
        nh = {hist[MAX_LEN-2:0], x};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
        fill_inc = (fill >= len) ? len : fill + LW'(1);
        sample = en && !cfg_load && !cfg_err && !rst;
        // fill counts only bits received since the last clear, so len-1 of them plus x form a full window
        match = sample
             && ((LW+1)'(fill) + (LW+1)'(1) >= (LW+1)'(len))
             && (((nh ^ pattern) & mask) == '0);
        z = !rst && (moore ? z_reg : match);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= '0;
            len       <= LW'(MAX_LEN);
            overlap   <= 1'b1;
            moore     <= 1'b1;
            hist      <= '0;
            fill      <= '0;
            z_reg     <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (clr_cnt)
                match_cnt <= '0;
            else if (match && match_cnt != '1)
                match_cnt <= match_cnt + CNT_W'(1);

            z_reg <= match;

            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                moore   <= cfg_moore;
                cfg_err <= (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
                hist    <= '0;
                fill    <= '0;
                z_reg   <= 1'b0;
            end else if (sample) begin
                hist <= nh;
                // non-overlap consumes the matched bits so they cannot seed the next match
                fill <= (match && !overlap) ? '0 : fill_inc;
            end
        end
    end
endmodule

// File: doc/seqdet_param.md
Name: seqdet_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 4-bit "1010" Moore/Mealy detectors in the FSM lab set.
- Detects a runtime-loadable pattern of 1..MAX_LEN bits on a serial input.
- Overlap/non-overlap and Mealy/Moore output are selectable at runtime, and the block counts matches.
- Used as a reusable detector in course labs and as the reference DUT for cocotb FSM exercises.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; must be ≥2.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  loads cfg_pattern, cfg_len, cfg_overlap and cfg_moore into internal registers.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received and bit [0] is the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_moore  in  1  1 = registered (Moore) output, 0 = combinational (Mealy) output.
- en  in  1  x is sampled only when en=1.
- x  in  1  serial data bit.
- clr_cnt  in  1  synchronous clear of match_cnt.
- z  out  1  match indication.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  loaded length is invalid; detection is disabled.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - pattern=0, len=MAX_LEN, overlap=1, moore=1;
  - hist=0, fill=0, z_reg=0, match_cnt=0, cfg_err=0.
- While rst=1, z=0 in both modes.
- Internal state:
  - hist[MAX_LEN-1:0] shift register of received bits; the newest bit is at bit 0.
  - fill, 0..len: number of valid bits in hist.
- Per sample (en=1, cfg_load=0, cfg_err=0):
  - nh = {hist[MAX_LEN-2:0], x}
  - match = (fill ≥ len-1) && (nh[len-1:0] == pattern[len-1:0]); compare only the low len bits.
- State update on a sample:
  - hist ← nh.
  - No match: fill ← min(fill+1, len).
  - Match with overlap=1: fill ← min(fill+1, len), so the suffix is retained.
  - Match with overlap=0: fill ← 0; bits of the matched pattern cannot contribute to the next match.
- en=0: hist and fill hold; match=0.
- Output timing:
  - Mealy (moore=0): z = match, combinational, in the same cycle as the final pattern bit; z_reg is still updated.
  - Moore (moore=1): z = z_reg, where z_reg ← match at each clk edge. z is high for exactly one cycle, the cycle after the final bit is sampled. If en=0 on the next cycle, z_reg returns to 0 after that one cycle.
- match_cnt:
  - Increments by 1 at the clk edge where match=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 clears it to 0 and takes priority over an increment in the same cycle.
- cfg_load=1 at a clk edge:
  - Latches all cfg_* inputs and clears hist, fill and z_reg.
  - x is discarded in that cycle even if en=1, and match is forced to 0.
  - match_cnt is unaffected.
- cfg_err=1 when the latched len is 0 or greater than MAX_LEN. While cfg_err=1, match=0 and z=0, with hist and fill held at 0. The next valid cfg_load clears cfg_err.
- len=1 is legal: every sample equal to pattern[0] matches.
  - Overlap and non-overlap behave identically.
  - Moore z stays high for consecutive matching samples.
- Reset asserted mid-sequence: a partial match is discarded, and the next match requires a full len bits after reset.
- Priority: rst > cfg_load > sample.

Test Plan:
- Default, pattern 1010: after reset, cfg_load with pattern=8'b00001010, len=4, overlap=1, moore=1. Stream en=1, x=1,0,1,0,1,0 → z high in the cycles after samples 4 and 6 only; match_cnt=2.
- Non-overlap: same stream with overlap=0 → single z pulse after sample 4; match_cnt=1. Stream 1,0,1,0,1,0,1,0 → pulses after samples 4 and 8.
- Mealy timing: moore=0, pattern 110, len=3. Stream 1,1,0 → z=1 combinationally during the third sample cycle. en=0 on the next cycle → z=0.
- en gaps and mid-sequence reset:
  - 1,0 then en=0 for 3 cycles, then 1,0 → match; en gaps do not break the sequence.
  - 1,0,1 then rst, then 0 → no match.
- Config edge cases:
  - len=0 → cfg_err=1; stream of x=1 gives z=0 and match_cnt unchanged.
  - len=MAX_LEN=8, pattern 8'hA5 → match only after 8 correct bits.
  - cfg_load coincident with en=1 → that x bit is ignored.
- Counter saturation (CNT_W=2): len=1, pattern 1, stream 5 ones → match_cnt=3. clr_cnt asserted together with a match → match_cnt=0.
